reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of entries; tag width is 4 bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port rdy  input  1  global enable; when 0, all state and registered outputs hold.
REQ-005 SHALL have ports issue_valid  input  1, issue_rd  input  5 and issue_is_br  input  1, carrying the new instruction's destination and branch flag.
REQ-006 SHALL have ports full  output  1 and issue_tag  output  4; issue_tag is the tail index assigned on accept.
REQ-007 SHALL have ports rf_in_flag  output  1, rf_in_a  output  5 and rf_in_rob  output  4, carrying the rename request to the register file.
REQ-008 SHALL have ports wb_valid  input  1, wb_tag  input  4, wb_val  input  32, wb_mispred  input  1 and wb_target  input  32, carrying the result writeback.
REQ-009 SHALL have query ports q1_tag and q2_tag  input  4, q1_ready and q2_ready  output  1, and q1_val and q2_val  output  32.
REQ-010 SHALL have ports rf_out_flag  output  1, rf_out_a  output  5, rf_out_val  output  32 and rf_out_rob  output  4, carrying the commit to the register file.
REQ-011 SHALL have ports flush  output  1 and flush_pc  output  32, carrying the mispredict redirect.

Function
REQ-012 SHALL store per entry: busy, done, rd, is_br, val[31:0], mispred, target[31:0]; SHALL keep head and tail indices and count[4:0].
REQ-013 full SHALL equal (count==DEPTH), from registered count only; it is combinational.
REQ-014 An issue SHALL be accepted when issue_valid && !full && rdy && no flush is generated this edge.
- On accept: entry[tail] is written busy=1, done=0, rd, is_br.
- tail wraps from DEPTH-1 to 0.
REQ-015 issue_tag SHALL equal tail, combinationally.
REQ-016 rf_in_flag SHALL equal (issue accepted && issue_rd!=0), combinationally; rf_in_a=issue_rd, rf_in_rob=tail.
REQ-017 Writeback, when wb_valid && rdy && entry[wb_tag].busy, SHALL set done=1 and store val, mispred and target; a writeback to a non-busy entry SHALL be ignored.
REQ-018 qN_ready SHALL be 1 iff entry[qN_tag] is busy&&done, or wb_valid&&wb_tag==qN_tag (bypass).
- qN_val SHALL take the bypassed wb_val when the bypass applies, else entry val; it SHALL be 0 when not ready.
REQ-019 Commit SHALL occur at an edge when rdy && entry[head].busy && entry[head].done.
- At most one commit per edge.
- The earliest commit is the edge after the one that recorded done (one-cycle writeback-to-commit latency).
REQ-020 On commit the outputs SHALL be registered for the following cycle:
- rf_out_flag=(rd!=0), rf_out_a=rd, rf_out_val=val, rf_out_rob=head;
- entry[head].busy is cleared; head advances with wrap.
REQ-021 rf_out_flag, flush SHALL be single-cycle pulses; they SHALL be 0 after any edge with no commit (when rdy=1).
REQ-022 If the committing head has is_br && mispred, the commit SHALL additionally register flush=1 and flush_pc=target.
- All entries are cleared to busy=0 and done=0; head=tail=0; count=0.
- Any same-edge issue is dropped, since it is younger than the branch.
REQ-023 count SHALL be +1 on accept only, -1 on commit only, and unchanged when both occur; a simultaneous commit SHALL NOT free a slot for the same-edge issue when full.
REQ-024 Writeback and commit in the same edge for different tags SHALL both take effect.

Reset
REQ-025 While rst=0, asynchronously: all busy/done=0, head=tail=count=0, rf_out_flag=0, rf_out_a=0, rf_out_val=0, rf_out_rob=0, flush=0, flush_pc=0.
REQ-026 After rst deasserts: full=0 and issue_tag=0; a reset mid-operation SHALL discard all entries with no commit pulse.

Verification
REQ-027 Issue rd=5 at tag 0, then wb tag0 val=0x1234 -> next cycle rf_out_flag=1, rf_out_a=5, rf_out_val=0x1234, rf_out_rob=0.
REQ-028 Issue 16 entries with no wb -> full=1; 17th issue is dropped; wb+commit of tag0 -> full=0 next cycle; tail wraps to 0.
REQ-029 Writebacks out of order (tag2, tag1, tag0) -> commits in order 0,1,2 on consecutive cycles.
REQ-030 Branch at tag1 with mispred=1, target=0x100, entries 2-4 pending -> after tag1 commits: flush=1 and flush_pc=0x100 for one cycle; count=0; later writebacks to tags 2-4 are ignored.
REQ-031 q1_tag=3 while wb tag3 val=7 in the same cycle -> q1_ready=1, q1_val=7.
REQ-032 rdy=0 with a ready head -> no commit and all outputs hold; asserting rst=0 mid-stream -> outputs 0 immediately and the buffer is empty.

Source files
------------

// File: rtl/reorder_buffer.sv
// In-order-commit reorder buffer: tags issued instructions, collects out-of-order
// writebacks, retires the head one per cycle and redirects on a mispredicted branch.
module reorder_buffer #(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   input  logic        issue_is_br,
   output logic        full,
   output logic [3:0]  issue_tag,
   output logic        rf_in_flag,
   output logic [4:0]  rf_in_a,
   output logic [3:0]  rf_in_rob,
   input  logic        wb_valid,
   input  logic [3:0]  wb_tag,
   input  logic [31:0] wb_val,
   input  logic        wb_mispred,
   input  logic [31:0] wb_target,
   input  logic [3:0]  q1_tag,
   input  logic [3:0]  q2_tag,
   output logic        q1_ready,
   output logic        q2_ready,
   output logic [31:0] q1_val,
   output logic [31:0] q2_val,
   output logic        rf_out_flag,
   output logic [4:0]  rf_out_a,
   output logic [31:0] rf_out_val,
   output logic [3:0]  rf_out_rob,
   output logic        flush,
   output logic [31:0] flush_pc
);

   // Storage spans the full 4-bit tag space; slots at or above DEPTH never become busy.
   localparam int NTAG = 16;

   logic [NTAG-1:0] busy_q, busy_d;
   logic [NTAG-1:0] done_q, done_d;
   logic [3:0]      head_q, head_d;
   logic [3:0]      tail_q, tail_d;
   logic [4:0]      count_q, count_d;

   logic [4:0]      rd_q     [NTAG];
   logic            br_q     [NTAG];
   logic [31:0]     val_q    [NTAG];
   logic            mp_q     [NTAG];
   logic [31:0]     tgt_q    [NTAG];

   logic            rf_out_flag_q, rf_out_flag_d;
   logic [4:0]      rf_out_a_q, rf_out_a_d;
   logic [31:0]     rf_out_val_q, rf_out_val_d;
   logic [3:0]      rf_out_rob_q, rf_out_rob_d;
   logic            flush_q, flush_d;
   logic [31:0]     flush_pc_q, flush_pc_d;

   logic            commit, flush_gen, accept, wb_en;
   logic            q1_hit, q2_hit;

   function automatic logic [3:0] wrap_inc(input logic [3:0] idx);
      return (idx == 4'(DEPTH - 1)) ? 4'd0 : idx + 4'd1;
   endfunction

   assign full      = (count_q == 5'(DEPTH));
   assign commit    = rdy && busy_q[head_q] && done_q[head_q];
   assign flush_gen = commit && br_q[head_q] && mp_q[head_q];
   assign accept    = issue_valid && !full && rdy && !flush_gen;
   assign wb_en     = wb_valid && rdy && busy_q[wb_tag];

   assign issue_tag  = tail_q;
   assign rf_in_flag = accept && (issue_rd != 5'd0);
   assign rf_in_a    = issue_rd;
   assign rf_in_rob  = tail_q;

   // Same-cycle writeback is forwarded to queries regardless of entry state.
   always_comb begin
      q1_hit   = wb_valid && (wb_tag == q1_tag);
      q2_hit   = wb_valid && (wb_tag == q2_tag);
      q1_ready = q1_hit || (busy_q[q1_tag] && done_q[q1_tag]);
      q2_ready = q2_hit || (busy_q[q2_tag] && done_q[q2_tag]);
      q1_val   = q1_hit ? wb_val : (q1_ready ? val_q[q1_tag] : 32'd0);
      q2_val   = q2_hit ? wb_val : (q2_ready ? val_q[q2_tag] : 32'd0);
   end

   always_comb begin
      busy_d        = busy_q;
      done_d        = done_q;
      head_d        = head_q;
      tail_d        = tail_q;
      count_d       = count_q;
      rf_out_flag_d = rf_out_flag_q;
      rf_out_a_d    = rf_out_a_q;
      rf_out_val_d  = rf_out_val_q;
      rf_out_rob_d  = rf_out_rob_q;
      flush_d       = flush_q;
      flush_pc_d    = flush_pc_q;
      if (rdy) begin
         rf_out_flag_d = 1'b0;
         flush_d       = 1'b0;
         if (wb_en) begin
            done_d[wb_tag] = 1'b1;
         end
         if (accept) begin
            busy_d[tail_q] = 1'b1;
            done_d[tail_q] = 1'b0;
            tail_d         = wrap_inc(tail_q);
         end
         // Commit is applied after writeback so a retiring head is always freed.
         if (commit) begin
            busy_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = wrap_inc(head_q);
            rf_out_flag_d  = (rd_q[head_q] != 5'd0);
            rf_out_a_d     = rd_q[head_q];
            rf_out_val_d   = val_q[head_q];
            rf_out_rob_d   = head_q;
         end
         if (accept && !commit) begin
            count_d = count_q + 5'd1;
         end else if (commit && !accept) begin
            count_d = count_q - 5'd1;
         end
         if (flush_gen) begin
            busy_d     = '0;
            done_d     = '0;
            head_d     = 4'd0;
            tail_d     = 4'd0;
            count_d    = 5'd0;
            flush_d    = 1'b1;
            flush_pc_d = tgt_q[head_q];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q        <= '0;
         done_q        <= '0;
         head_q        <= 4'd0;
         tail_q        <= 4'd0;
         count_q       <= 5'd0;
         rf_out_flag_q <= 1'b0;
         rf_out_a_q    <= 5'd0;
         rf_out_val_q  <= 32'd0;
         rf_out_rob_q  <= 4'd0;
         flush_q       <= 1'b0;
         flush_pc_q    <= 32'd0;
      end else begin
         busy_q        <= busy_d;
         done_q        <= done_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         rf_out_flag_q <= rf_out_flag_d;
         rf_out_a_q    <= rf_out_a_d;
         rf_out_val_q  <= rf_out_val_d;
         rf_out_rob_q  <= rf_out_rob_d;
         flush_q       <= flush_d;
         flush_pc_q    <= flush_pc_d;
      end
   end

   // Payload is only meaningful while busy, so it carries no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         rd_q[tail_q] <= issue_rd;
         br_q[tail_q] <= issue_is_br;
      end
      if (wb_en) begin
         val_q[wb_tag] <= wb_val;
         mp_q[wb_tag]  <= wb_mispred;
         tgt_q[wb_tag] <= wb_target;
      end
   end

   assign rf_out_flag = rf_out_flag_q;
   assign rf_out_a    = rf_out_a_q;
   assign rf_out_val  = rf_out_val_q;
   assign rf_out_rob  = rf_out_rob_q;
   assign flush       = flush_q;
   assign flush_pc    = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios then random traffic, all checked
// against a queue-based model of in-flight instructions.
module tb_reorder_buffer;

   logic        clk = 1'b0;
   logic        rst, rdy, issue_valid, issue_is_br, wb_valid, wb_mispred;
   logic [4:0]  issue_rd;
   logic [3:0]  wb_tag, q1_tag, q2_tag;
   logic [31:0] wb_val, wb_target;
   logic        full, rf_in_flag, q1_ready, q2_ready, rf_out_flag, flush;
   logic [3:0]  issue_tag, rf_in_rob, rf_out_rob;
   logic [4:0]  rf_in_a, rf_out_a;
   logic [31:0] q1_val, q2_val, rf_out_val, flush_pc;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   reorder_buffer #(.DEPTH(16)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_br(issue_is_br),
      .full(full), .issue_tag(issue_tag),
      .rf_in_flag(rf_in_flag), .rf_in_a(rf_in_a), .rf_in_rob(rf_in_rob),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
      .wb_mispred(wb_mispred), .wb_target(wb_target),
      .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
      .q1_val(q1_val), .q2_val(q2_val),
      .rf_out_flag(rf_out_flag), .rf_out_a(rf_out_a), .rf_out_val(rf_out_val),
      .rf_out_rob(rf_out_rob), .flush(flush), .flush_pc(flush_pc)
   );

   // Model: program-ordered list of in-flight instructions, oldest first.
   typedef struct {
      logic [3:0]  tag;
      logic [4:0]  rd;
      logic        br;
      logic        done;
      logic [31:0] val;
      logic        mp;
      logic [31:0] tgt;
   } ent_t;

   ent_t        m_q[$];
   int          m_head;
   logic        e_flag, e_flush;
   logic [4:0]  e_a;
   logic [31:0] e_val, e_pc;
   logic [3:0]  e_rob;
   logic        dq1r;
   logic [31:0] dq1v;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   function automatic int find(input logic [3:0] t);
      foreach (m_q[i]) if (m_q[i].tag == t) return i;
      return -1;
   endfunction

   function automatic logic [32:0] q_exp(input logic [3:0] t, input logic wv,
                                         input logic [3:0] wt, input logic [31:0] wval);
      int i;
      i = find(t);
      if (wv && wt == t) return {1'b1, wval};
      if (i >= 0 && m_q[i].done) return {1'b1, m_q[i].val};
      return 33'd0;
   endfunction

   task automatic model_clear();
      m_q.delete();
      m_head  = 0;
      e_flag  = 1'b0; e_a = 5'd0; e_val = 32'd0; e_rob = 4'd0;
      e_flush = 1'b0; e_pc = 32'd0;
   endtask

   task automatic drive_idle();
      rdy = 1'b1; issue_valid = 1'b0; issue_rd = 5'd0; issue_is_br = 1'b0;
      wb_valid = 1'b0; wb_tag = 4'd0; wb_val = 32'd0; wb_mispred = 1'b0;
      wb_target = 32'd0; q1_tag = 4'd0; q2_tag = 4'd0;
   endtask

   // Entered and left just after a falling edge.
   task automatic do_reset();
      rst = 1'b0;
      drive_idle();
      #1;
      chk("rst_flag", 32'(rf_out_flag), 32'd0);
      chk("rst_a", 32'(rf_out_a), 32'd0);
      chk("rst_val", rf_out_val, 32'd0);
      chk("rst_rob", 32'(rf_out_rob), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_pc", flush_pc, 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_tag", 32'(issue_tag), 32'd0);
      model_clear();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic step(input logic iv, input logic [4:0] ird, input logic ibr,
                       input logic wv, input logic [3:0] wt, input logic [31:0] wval,
                       input logic wmp, input logic [31:0] wtgt, input logic r,
                       input logic [3:0] t1, input logic [3:0] t2,
                       output logic o_q1r, output logic [31:0] o_q1v);
      int          sz, idx;
      logic [3:0]  tl;
      logic        cm, fl, acc;
      logic [32:0] e1, e2;
      ent_t        c, n;
      issue_valid = iv; issue_rd = ird; issue_is_br = ibr;
      wb_valid = wv; wb_tag = wt; wb_val = wval; wb_mispred = wmp; wb_target = wtgt;
      rdy = r; q1_tag = t1; q2_tag = t2;
      sz  = m_q.size();
      tl  = 4'((m_head + sz) % 16);
      cm  = r && (sz > 0) && m_q[0].done;
      fl  = cm && m_q[0].br && m_q[0].mp;
      acc = iv && (sz < 16) && r && !fl;
      e1  = q_exp(t1, wv, wt, wval);
      e2  = q_exp(t2, wv, wt, wval);
      #1;
      chk("full", 32'(full), 32'(sz == 16));
      chk("issue_tag", 32'(issue_tag), 32'(tl));
      chk("rf_in_flag", 32'(rf_in_flag), 32'(acc && ird != 5'd0));
      chk("rf_in_a", 32'(rf_in_a), 32'(ird));
      chk("rf_in_rob", 32'(rf_in_rob), 32'(tl));
      chk("q1_ready", 32'(q1_ready), 32'(e1[32]));
      chk("q1_val", q1_val, e1[31:0]);
      chk("q2_ready", 32'(q2_ready), 32'(e2[32]));
      chk("q2_val", q2_val, e2[31:0]);
      o_q1r = q1_ready;
      o_q1v = q1_val;
      @(posedge clk);
      if (r) begin
         e_flag  = 1'b0;
         e_flush = 1'b0;
         if (cm) begin
            c      = m_q[0];
            e_flag = (c.rd != 5'd0);
            e_a    = c.rd;
            e_val  = c.val;
            e_rob  = c.tag;
            if (fl) begin
               e_flush = 1'b1;
               e_pc    = c.tgt;
            end
         end
         if (wv) begin
            idx = find(wt);
            if (idx >= 0) begin
               n = m_q[idx];
               n.done = 1'b1; n.val = wval; n.mp = wmp; n.tgt = wtgt;
               m_q[idx] = n;
            end
         end
         if (cm) begin
            void'(m_q.pop_front());
            m_head = (m_head + 1) % 16;
         end
         if (acc) begin
            n.tag = tl; n.rd = ird; n.br = ibr; n.done = 1'b0;
            n.val = 32'd0; n.mp = 1'b0; n.tgt = 32'd0;
            m_q.push_back(n);
         end
         if (fl) begin
            m_q.delete();
            m_head = 0;
         end
      end
      #1;
      chk("rf_out_flag", 32'(rf_out_flag), 32'(e_flag));
      chk("rf_out_a", 32'(rf_out_a), 32'(e_a));
      chk("rf_out_val", rf_out_val, e_val);
      chk("rf_out_rob", 32'(rf_out_rob), 32'(e_rob));
      chk("flush", 32'(flush), 32'(e_flush));
      chk("flush_pc", flush_pc, e_pc);
      @(negedge clk);
   endtask

   task automatic idle(input logic r);
      step(0, 0, 0, 0, 0, 0, 0, 0, r, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), dq1r, dq1v);
   endtask

   task automatic iss(input logic [4:0] rd, input logic br);
      step(1, rd, br, 0, 0, 0, 0, 0, 1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), dq1r, dq1v);
   endtask

   task automatic wbk(input logic [3:0] t, input logic [31:0] v, input logic mp, input logic [31:0] tg);
      step(0, 0, 0, 1, t, v, mp, tg, 1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), dq1r, dq1v);
   endtask

   initial begin
      int          pend[$];
      logic        iv, ibr, wv, wmp, r, qr;
      logic [4:0]  ird;
      logic [3:0]  wt, t1, t2;
      logic [31:0] wval, wtgt, qv;

      rst = 1'b0;
      drive_idle();
      model_clear();
      @(negedge clk);
      do_reset();
      idle(1);

      // Single instruction: issue, writeback, commit.
      iss(5'd5, 1'b0);
      wbk(4'd0, 32'h1234, 1'b0, 32'd0);
      idle(1);
      chk("basic_flag", 32'(rf_out_flag), 32'd1);
      chk("basic_a", 32'(rf_out_a), 32'd5);
      chk("basic_val", rf_out_val, 32'h1234);
      chk("basic_rob", 32'(rf_out_rob), 32'd0);

      // Fill to capacity, overflow attempt, then free one slot.
      do_reset();
      for (int i = 0; i < 16; i++) iss(5'(i + 1), 1'b0);
      chk("fill_full", 32'(full), 32'd1);
      iss(5'd9, 1'b0);
      wbk(4'd0, 32'hAA, 1'b0, 32'd0);
      idle(1);
      chk("fill_freed", 32'(full), 32'd0);
      chk("fill_wrap", 32'(issue_tag), 32'd0);
      iss(5'd3, 1'b0);

      // Out-of-order writeback, in-order retirement.
      do_reset();
      iss(5'd1, 1'b0); iss(5'd2, 1'b0); iss(5'd3, 1'b0);
      wbk(4'd2, 32'h22, 1'b0, 32'd0);
      wbk(4'd1, 32'h11, 1'b0, 32'd0);
      wbk(4'd0, 32'h10, 1'b0, 32'd0);
      for (int i = 0; i < 4; i++) idle(1);

      // Mispredicted branch at tag 1 with younger entries pending.
      do_reset();
      iss(5'd1, 1'b0); iss(5'd2, 1'b1); iss(5'd3, 1'b0); iss(5'd4, 1'b0); iss(5'd6, 1'b0);
      step(0, 0, 0, 1, 4'd3, 32'd7, 0, 0, 1, 4'd3, 4'd0, qr, qv);
      chk("bypass_ready", 32'(qr), 32'd1);
      chk("bypass_val", qv, 32'd7);
      wbk(4'd0, 32'h50, 1'b0, 32'd0);
      wbk(4'd1, 32'h60, 1'b1, 32'h100);
      idle(1);
      chk("br_flush", 32'(flush), 32'd1);
      chk("br_pc", flush_pc, 32'h100);
      chk("br_empty", 32'(issue_tag), 32'd0);
      idle(1);
      wbk(4'd2, 32'h1, 1'b0, 32'd0);
      wbk(4'd3, 32'h2, 1'b0, 32'd0);
      wbk(4'd4, 32'h3, 1'b0, 32'd0);
      idle(1); idle(1);

      // Stall with a ready head, then reset mid-stream.
      do_reset();
      iss(5'd5, 1'b0); iss(5'd6, 1'b0);
      wbk(4'd0, 32'hA, 1'b0, 32'd0);
      wbk(4'd1, 32'hB, 1'b0, 32'd0);
      idle(0); idle(0);
      chk("stall_flag", 32'(rf_out_flag), 32'd1);
      chk("stall_rob", 32'(rf_out_rob), 32'd0);
      do_reset();
      idle(1); idle(1);

      // Random traffic.
      for (int n = 0; n < 800; n++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         pend.delete();
         foreach (m_q[i]) if (!m_q[i].done) pend.push_back(int'(m_q[i].tag));
         iv   = ($urandom_range(0, 9) < 6);
         ird  = 5'($urandom_range(0, 31));
         ibr  = ($urandom_range(0, 2) == 0);
         wv   = ($urandom_range(0, 9) < 6);
         if (pend.size() > 0 && $urandom_range(0, 3) != 0)
            wt = 4'(pend[$urandom_range(0, pend.size() - 1)]);
         else
            wt = 4'($urandom_range(0, 15));
         wval = $urandom;
         wmp  = ($urandom_range(0, 7) == 0);
         wtgt = $urandom;
         r    = ($urandom_range(0, 9) != 0);
         t1   = ($urandom_range(0, 2) == 0) ? wt : 4'($urandom_range(0, 15));
         t2   = 4'($urandom_range(0, 15));
         step(iv, ird, ibr, wv, wt, wval, wmp, wtgt, r, t1, t2, qr, qv);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
